// File: rtl/status_serializer.sv
// status_serializer: framed serial transmitter (start, data LSB first, optional even parity, stop)
module status_serializer #(
   parameter int WIDTH      = 9,
   parameter int BIT_CYCLES = 4,
   parameter int PARITY_EN  = 1
) (
   input  logic             i_sysclk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_status_in,
   input  logic             i_status_valid,
   output logic             o_status_ready,
   output logic             o_sout,
   output logic             o_busy,
   output logic             o_done
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam int CW = $clog2(BIT_CYCLES + 1);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] C_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);
   localparam logic [BW-1:0] B_ONE  = BW'(1);
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [BW-1:0]    r_bits;
   logic [WIDTH-1:0] r_shift;
   logic             r_par;
   logic             r_sout;
   logic             r_busy;
   logic             r_done;
   logic             r_rdy_en;
   logic [WIDTH-1:0] w_shifted;
   logic             w_accept;
   logic             w_tick;
   assign w_shifted      = r_shift >> 1;
   assign w_tick         = (r_cnt == '0);
   // ready is held low until the first edge after reset release
   assign o_status_ready = r_rdy_en & (r_state == IDLE);
   assign w_accept       = i_status_valid & o_status_ready;
   assign o_sout         = r_sout;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   always_ff @(posedge i_sysclk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_bits   <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_sout   <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         r_done   <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               r_state <= START;
               r_cnt   <= C_LAST;
               r_shift <= i_status_in;
               r_par   <= ^i_status_in;
               r_sout  <= 1'b0;
               r_busy  <= 1'b1;
            end
            START: if (!w_tick) r_cnt <= r_cnt - C_ONE;
            else begin
               r_state <= DATA;
               r_cnt   <= C_LAST;
               r_bits  <= B_LAST;
               r_sout  <= r_shift[0];
            end
            DATA: if (!w_tick) r_cnt <= r_cnt - C_ONE;
            else if (r_bits != '0) begin
               r_cnt   <= C_LAST;
               r_bits  <= r_bits - B_ONE;
               r_shift <= w_shifted;
               r_sout  <= w_shifted[0];
            end else if (PARITY_EN != 0) begin
               r_state <= PARITY;
               r_cnt   <= C_LAST;
               r_sout  <= r_par;
            end else begin
               r_state <= STOP;
               r_cnt   <= C_LAST;
               r_sout  <= 1'b1;
               r_done  <= (C_LAST == '0);
            end
            PARITY: if (!w_tick) r_cnt <= r_cnt - C_ONE;
            else begin
               r_state <= STOP;
               r_cnt   <= C_LAST;
               r_sout  <= 1'b1;
               r_done  <= (C_LAST == '0);
            end
            STOP: if (!w_tick) begin
               r_cnt  <= r_cnt - C_ONE;
               r_done <= (r_cnt == C_ONE);
            end else begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_status_serializer.sv
// tb_status_serializer: scoreboard bench with a frame-level reference model
module tb_status_serializer;
   localparam int N = 48;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [8:0] in_w = '0, in6 = '0;
   logic v = 1'b0, v6 = 1'b0;
   logic rdy, s, b, d, rdy6, s6, b6, d6;
   logic [8:0] sb[$];
   int n_chk = 0, n_pass = 0;
   int n_exp_frames = 0, n_done = 0, mcnt = 0, gap = 0, last_gap = 0;
   bit post = 0;
   logic [63:0] sv, dv, bv, rv;

   always #5 clk = ~clk;

   status_serializer #(.WIDTH(9), .BIT_CYCLES(4), .PARITY_EN(1)) dut (
      .i_sysclk(clk), .i_reset(rst), .i_status_in(in_w), .i_status_valid(v),
      .o_status_ready(rdy), .o_sout(s), .o_busy(b), .o_done(d));

   status_serializer #(.WIDTH(9), .BIT_CYCLES(1), .PARITY_EN(0)) dut6 (
      .i_sysclk(clk), .i_reset(rst), .i_status_in(in6), .i_status_valid(v6),
      .o_status_ready(rdy6), .o_sout(s6), .o_busy(b6), .o_done(d6));

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // expected sout per cycle: frame bit list expanded by bit duration
   function automatic logic [63:0] frame_exp(input logic [8:0] w, input int bc, input int par);
      logic [11:0] bits;
      logic [63:0] r;
      int nb;
      nb = 11 + par;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 9; i++) bits[i+1] = w[i];
      if (par != 0) bits[10] = ^w;
      r = '0;
      for (int c = 0; c < nb * bc; c++) r[c] = bits[c / bc];
      return r;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mcnt = 0;
            gap = 0;
            post = 0;
         end else begin
            if (d) n_done++;
            if (b || mcnt != 0) begin
               if (mcnt == 0) begin
                  last_gap = gap;
                  sv = '0; dv = '0; bv = '0; rv = '0;
               end
               sv[mcnt] = s; dv[mcnt] = d; bv[mcnt] = b; rv[mcnt] = rdy;
               mcnt++;
               if (mcnt == N) begin
                  if (sb.size() == 0) chk(1'b0, "unexpected_frame", sv, 0);
                  else begin
                     logic [8:0] w;
                     logic [63:0] e;
                     w = sb.pop_front();
                     e = frame_exp(w, 4, 1);
                     chk(sv == e, "sout_stream", sv, e);
                     chk(dv == (64'd1 << (N - 1)), "done_pulse", dv, 64'd1 << (N - 1));
                     chk(bv == ((64'd1 << N) - 1), "busy_len", bv, (64'd1 << N) - 1);
                     chk(rv == 0, "ready_low", rv, 0);
                  end
                  mcnt = 0;
                  post = 1;
                  gap = 0;
               end
            end else begin
               if (post) chk(rdy && s && !d, "post_frame_idle", {rdy, s, d}, 3'b110);
               post = 0;
               gap++;
            end
         end
      end
   end

   task automatic send(input logic [8:0] w, input bit keep, input logic [8:0] nxt);
      int t;
      t = 0;
      @(negedge clk);
      in_w = w;
      v = 1'b1;
      while (!rdy && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!rdy) begin
         chk(1'b0, "accept_timeout", 0, 1);
         v = 1'b0;
         return;
      end
      sb.push_back(w);
      n_exp_frames++;
      @(posedge clk);
      #1;
      in_w = nxt;
      v = keep;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk(sb.size() == 0, "drain_timeout", sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [63:0] e6, s6v, d6v, b6v;
      bit ok;
      int dn;
      #12;
      chk({rdy, s, b, d} == 4'b0100, "reset_state", {rdy, s, b, d}, 4'b0100);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk(rdy == 1'b0, "ready_before_edge", rdy, 0);
      @(posedge clk);
      #1;
      chk(rdy && rdy6, "ready_after_edge", {rdy, rdy6}, 2'b11);
      // single-cycle bit configuration
      @(negedge clk);
      in6 = 9'h001;
      v6 = 1'b1;
      @(posedge clk);
      #1;
      v6 = 1'b0;
      in6 = 9'h1FE;
      s6v = '0; d6v = '0; b6v = '0;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         s6v[c] = s6; d6v[c] = d6; b6v[c] = b6;
      end
      e6 = frame_exp(9'h001, 1, 0);
      chk(s6v == e6, "bc1_sout", s6v, e6);
      chk(d6v == (64'd1 << 10), "bc1_done", d6v, 64'd1 << 10);
      chk(b6v == 64'h7FF, "bc1_busy", b6v, 64'h7FF);
      @(negedge clk);
      chk(rdy6 && !b6 && s6, "bc1_idle", {rdy6, b6, s6}, 3'b101);
      // directed frames
      send(9'h1A5, 0, 9'h000);
      drain();
      send(9'h000, 0, 9'h000);
      drain();
      dn = n_done;
      send(9'h0FF, 1, 9'h100);
      send(9'h100, 0, 9'h000);
      drain();
      chk(last_gap == 1, "b2b_gap", last_gap, 1);
      chk(n_done - dn == 2, "b2b_done_count", n_done - dn, 2);
      send(9'h155, 0, 9'h0AA);
      drain();
      // randomized frames with input changes after acceptance
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(9'($urandom), 0, 9'($urandom));
      end
      drain();
      // reset in the middle of a frame
      send(9'($urandom), 0, 9'($urandom));
      repeat (19) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk({s, b, d, rdy} == 4'b1000, "midframe_reset", {s, b, d, rdy}, 4'b1000);
      sb.delete();
      n_exp_frames--;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk(rdy == 1'b0, "rerelease_ready_low", rdy, 0);
      @(posedge clk);
      #1;
      chk(rdy == 1'b1, "rerelease_ready", rdy, 1);
      ok = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         ok &= (!b && s && !d);
      end
      chk(ok, "no_resume", ok, 1);
      send(9'h1A5, 0, 9'h000);
      drain();
      chk(n_done == n_exp_frames, "done_total", n_done, n_exp_frames);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
